// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver state encoding,
// common to the receiver, the baud generator and the future transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VAL so the output is a known level straight out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so that r_sync picks
  // up the old r_meta, giving a true two-stage pipeline.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification, mid-bit data sampling and
// stop-bit check, all paced by the oversample tick from the baud generator.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  uart_rx_state_t       r_state;
  logic [SW-1:0]        r_s_cnt;
  logic [BW-1:0]        r_b_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 w_rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_s_cnt     <= '0;
      r_b_cnt     <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Pulses fall on the clk after they are raised, whether or not tick is high.
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (tick) begin
        unique case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state <= START;
              r_s_cnt <= '0;
            end
          end
          START: begin
            if (r_s_cnt == S_MID) begin
              // A start bit that is high again at its centre was only a glitch.
              r_s_cnt <= '0;
              r_b_cnt <= '0;
              r_state <= w_rx_s ? IDLE : DATA;
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
          DATA: begin
            if (r_s_cnt == S_LAST) begin
              r_s_cnt <= '0;
              r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_b_cnt == B_LAST) r_state <= STOP;
              else                   r_b_cnt <= r_b_cnt + 1'b1;
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
          STOP: begin
            if (r_s_cnt == S_LAST) begin
              r_s_cnt <= '0;
              if (w_rx_s) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_state    <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= BREAK;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
          BREAK: begin
            // Wait out a held-low line so it cannot retrigger as a new start.
            if (w_rx_s) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 100 MHz clk, tick every 54 clk (bit = 864 clk),
// frames driven bit by bit and outputs observed on the falling clk edge.
module tb_uart_rx;

  localparam int DIV     = 54;
  localparam int BIT_CLK = DIV * 16;
  localparam int NOM_LAT = (BIT_CLK * 19) / 2;
  localparam int LAT_TOL = DIV + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  logic       tick_en;
  int         div_cnt = 0;
  int         cyc = 0;

  int         n_checks = 0;
  int         n_fail = 0;

  logic [7:0] got_q[$];
  int         valid_cyc[$];
  int         ferr_cnt = 0;
  logic       busy_seen = 1'b0;
  int         start_cyc;

  uart_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    div_cnt <= (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
  end

  assign tick = tick_en && (div_cnt == DIV - 1);

  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      valid_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop);
  endtask

  initial begin
    int n0;
    int f0;
    int lat;

    reset_n = 1'b0;
    rx      = 1'b1;
    tick_en = 1'b1;
    wait_clk(5);
    check("rst_data",  rx_data,   0);
    check("rst_valid", rx_valid,  0);
    check("rst_ferr",  frame_err, 0);
    check("rst_busy",  busy,      0);
    reset_n = 1'b1;
    wait_clk(20);

    // Single 0xA5 frame with latency measured from the start edge.
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1);
    check("a5_count", got_q.size(), 1);
    check("a5_data",  q_at(0), 8'hA5);
    check("a5_ferr",  ferr_cnt, 0);
    lat = (valid_cyc.size() > 0) ? valid_cyc[0] - start_cyc : 0;
    check("a5_latency_ok", (lat >= NOM_LAT - LAT_TOL) && (lat <= NOM_LAT + LAT_TOL), 1);

    // 0x00 then 0xFF back to back with no idle between frames.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1);
    check("b2b_count", got_q.size(), 3);
    check("b2b_data0", q_at(1), 8'h00);
    check("b2b_data1", q_at(2), 8'hFF);
    check("b2b_ferr",  ferr_cnt, 0);
    check("b2b_rxdata", rx_data, 8'hFF);

    // Four-tick low glitch on an idle line.
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_clk(4 * DIV);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end",  busy, 0);
    check("glitch_count",     got_q.size(), 3);
    check("glitch_ferr",      ferr_cnt, 0);
    check("glitch_rxdata",    rx_data, 8'hFF);

    // 0x55 with a low stop bit, line held low, then a clean 0x3C.
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    wait_clk(3 * BIT_CLK);
    check("ferr_count",  ferr_cnt, 1);
    check("ferr_novalid", got_q.size(), 3);
    check("ferr_rxdata", rx_data, 8'hFF);
    check("ferr_busy_low", busy, 1);
    drive_bit(1'b1);
    check("ferr_busy_idle", busy, 0);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1);
    check("ferr_next_count", got_q.size(), 4);
    check("ferr_next_data",  q_at(3), 8'h3C);
    check("ferr_count_end",  ferr_cnt, 1);

    // Reset pulse halfway through data bit 4 of 0x81.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
    rx = 1'b0;
    wait_clk(BIT_CLK / 2);
    reset_n = 1'b0;
    rx      = 1'b1;
    wait_clk(1);
    check("mrst_data",  rx_data,   0);
    check("mrst_valid", rx_valid,  0);
    check("mrst_ferr",  frame_err, 0);
    check("mrst_busy",  busy,      0);
    reset_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("mrst_no_valid", got_q.size(), 4);
    check("mrst_no_ferr",  ferr_cnt, 1);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1);
    check("mrst_next_count", got_q.size(), 5);
    check("mrst_next_data",  rx_data, 8'h81);

    // tick held low while rx toggles at random.
    tick_en   = 1'b0;
    wait_clk(2);
    busy_seen = 1'b0;
    n0 = got_q.size();
    f0 = ferr_cnt;
    for (int i = 0; i < 2000; i++) begin
      rx = 1'($urandom_range(0, 1));
      wait_clk(1);
    end
    rx = 1'b1;
    wait_clk(4);
    check("notick_busy_seen", busy_seen, 0);
    check("notick_count",     got_q.size(), n0);
    check("notick_ferr",      ferr_cnt, f0);
    check("notick_rxdata",    rx_data, 8'h81);
    tick_en = 1'b1;
    wait_clk(BIT_CLK);
    check("notick_busy_end",  busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
